// File: rtl/polirv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
package polirv_mem_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Requester identifiers, also used as the req[] bit index.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Memory word width.
    localparam int WORD_BITS = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the requester
// that did not win last time is chosen.
module rr_arbiter2
    import polirv_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    // Combinational pick of the next grant.
    always_comb begin
        valid_o = |req_i;
        grant_o = GRANT_I;
        case (req_i)
            2'b01:   grant_o = GRANT_I;
            2'b10:   grant_o = GRANT_D;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = GRANT_I;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 64-bit memory between the instruction-fetch port
// and the data port. Each access runs IDLE -> ACCESS -> WAIT x MEM_LATENCY
// -> RESP, and all outputs are registered.
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch the request on entry to ACCESS
// ACCESS | m_en strobe cycle; load the latency counter
// WAIT   | counting down the memory latency; capture m_rdata when count is 1
// RESP   | one-cycle ack to the granted requester
module mem_arbiter
    import polirv_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 6,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [ADDR_BITS:0]   i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [WORD_BITS-1:0] d_wdata,
    output logic [WORD_BITS-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 m_en,
    output logic                 m_we,
    output logic [ADDR_BITS-1:0] m_addr,
    output logic [WORD_BITS-1:0] m_wdata,
    input  logic [WORD_BITS-1:0] m_rdata
);

    localparam int CNT_BITS = 4;

    state_t                 state_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic                   last_grant_q;
    logic                   grant_q;
    logic                   half_q;
    logic                   m_en_q;
    logic                   m_we_q;
    logic [ADDR_BITS-1:0]   m_addr_q;
    logic [WORD_BITS-1:0]   m_wdata_q;
    logic                   i_ack_q;
    logic                   d_ack_q;
    logic [31:0]            i_rdata_q;
    logic [WORD_BITS-1:0]   d_rdata_q;

    logic                   pick_grant;
    logic                   pick_valid;

    rr_arbiter2 u_rr (
        .req_i        ({d_req, i_req}),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_grant),
        .valid_o      (pick_valid)
    );

    // Sequencing FSM with registered memory strobes, acks and response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= GRANT_I;
            grant_q      <= GRANT_I;
            half_q       <= 1'b0;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick_grant;
                        last_grant_q <= pick_grant;
                        m_en_q       <= 1'b1;
                        if (pick_grant == GRANT_D) begin
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                            m_we_q    <= d_we;
                        end else begin
                            m_addr_q  <= i_addr[ADDR_BITS:1];
                            half_q    <= i_addr[0];
                            m_we_q    <= 1'b0;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    m_en_q  <= 1'b0;
                    m_we_q  <= 1'b0;
                    cnt_q   <= CNT_BITS'(MEM_LATENCY);
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_BITS'(1)) begin
                        if (grant_q == GRANT_D) begin
                            d_rdata_q <= m_rdata;
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= half_q ? m_rdata[63:32] : m_rdata[31:0];
                            i_ack_q   <= 1'b1;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-1 instance checked every cycle against a
// transaction-level model, plus a latency-4 instance with directed checks.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] init_word(input int i);
        if (i == 3) return 64'hDEADBEEF_00000013;
        return {32'hC0DE0000 | 32'(i), 32'h00001000 | 32'(i)};
    endfunction

    // ---------------- instance A : MEM_LATENCY = 1 ----------------
    localparam int LAT_A = 1;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [6:0]  i_addr = '0;
    logic [5:0]  d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic [31:0] i_rdata;
    logic [63:0] d_rdata, m_wdata, m_rdata;
    logic        i_ack, d_ack, m_en, m_we;
    logic [5:0]  m_addr;

    mem_arbiter #(.ADDR_BITS(6), .MEM_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    logic [63:0] mem_a [64];
    logic [5:0]  rd_addr_a = '0;
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem_a[m_addr] <= m_wdata;
            rd_addr_a <= m_addr;
        end
    end
    assign m_rdata = mem_a[rd_addr_a];

    // ---------------- instance B : MEM_LATENCY = 4 ----------------
    logic        b_rst = 1'b1;
    logic        b_i_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [6:0]  b_i_addr = '0;
    logic [5:0]  b_d_addr = '0;
    logic [63:0] b_d_wdata = '0;
    logic [31:0] b_i_rdata;
    logic [63:0] b_d_rdata, b_m_wdata, b_m_rdata;
    logic        b_i_ack, b_d_ack, b_m_en, b_m_we;
    logic [5:0]  b_m_addr;

    mem_arbiter #(.ADDR_BITS(6), .MEM_LATENCY(4)) dut_b (
        .clk(clk), .rst(b_rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_rdata(b_m_rdata)
    );

    logic [63:0] mem_b [64];
    logic [5:0]  rd_addr_b = '0;
    always @(posedge clk) begin
        if (b_m_en) begin
            if (b_m_we) mem_b[b_m_addr] <= b_m_wdata;
            rd_addr_b <= b_m_addr;
        end
    end
    assign b_m_rdata = mem_b[rd_addr_b];

    // ---------------- transaction-level model of instance A ----------------
    logic [63:0] model_mem [64];
    bit          have, t_d, t_we, t_half, last_d, dknown, e_en, e_ack, g_d;
    int          en_cyc, ack_cyc, en_cnt, dack_cnt;
    logic [5:0]  t_addr;
    logic [63:0] t_wd, rd, exp_dr;
    logic [31:0] exp_ir;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i]     = init_word(i);
            mem_b[i]     = init_word(i);
            model_mem[i] = init_word(i);
        end
    end

    initial begin
        have = 0; last_d = 0; dknown = 1; exp_ir = '0; exp_dr = '0;
        en_cnt = 0; dack_cnt = 0; en_cyc = 0; ack_cyc = 0; rd = '0;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                e_en  = have && (cyc == en_cyc);
                e_ack = have && (cyc == ack_cyc);
                if (e_ack && !t_d) exp_ir = t_half ? rd[63:32] : rd[31:0];
                if (e_ack && t_d) begin
                    if (t_we) dknown = 0;
                    else begin exp_dr = rd; dknown = 1; end
                end
                chk("m_en", 64'(m_en), 64'(e_en));
                chk("m_we", 64'(m_we), 64'(e_en && t_we));
                if (e_en) chk("m_addr", 64'(m_addr), 64'(t_addr));
                if (e_en && t_we) chk("m_wdata", m_wdata, t_wd);
                chk("i_ack", 64'(i_ack), 64'(e_ack && !t_d));
                chk("d_ack", 64'(d_ack), 64'(e_ack && t_d));
                chk("i_rdata", 64'(i_rdata), 64'(exp_ir));
                if (dknown) chk("d_rdata", d_rdata, exp_dr);
                if (m_en === 1'b1) en_cnt++;
                if (d_ack === 1'b1) dack_cnt++;
                if (e_en) begin
                    if (t_we) model_mem[t_addr] = t_wd;
                    rd = model_mem[t_addr];
                end
                if (rst) begin
                    have = 0; last_d = 0; exp_ir = '0; exp_dr = '0; dknown = 1;
                end else if (!have || cyc > ack_cyc) begin
                    have = 0;
                    if (i_req || d_req) begin
                        g_d = (i_req && d_req) ? !last_d : d_req;
                        have = 1; t_d = g_d; last_d = g_d;
                        t_we   = g_d ? d_we : 1'b0;
                        t_addr = g_d ? d_addr : i_addr[6:1];
                        t_half = i_addr[0];
                        t_wd   = d_wdata;
                        en_cyc  = cyc + 1;
                        ack_cyc = cyc + 2 + LAT_A;
                    end
                end
            end
        end
    end

    // Bounded wait for any ack on instance A; latency counted from the call cycle.
    task automatic wait_a(input string nm, output int lat);
        int start;
        bit got;
        start = cyc;
        got = 0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (i_ack === 1'b1 || d_ack === 1'b1) got = 1;
        end
        lat = cyc - start;
        if (!got) begin
            n_checks++; n_err++;
            $display("FAIL %s: no ack within 60 cycles", nm);
        end
    endtask

    task automatic run_d(input string nm, input bit we, input logic [5:0] a,
                         input logic [63:0] wd, output int lat, output logic [63:0] rdv);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        wait_a(nm, lat);
        chk({nm, "_is_d"}, 64'(d_ack), 64'd1);
        rdv = d_rdata;
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic run_i(input string nm, input logic [6:0] a,
                         output int lat, output logic [31:0] rdv);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = a;
        wait_a(nm, lat);
        chk({nm, "_is_i"}, 64'(i_ack), 64'd1);
        rdv = i_rdata;
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    // ---------------- instance B directed sequence ----------------
    int b_en_cnt = 0;
    bit b_done = 0;
    initial forever begin
        @(negedge clk);
        if (b_m_en === 1'b1) b_en_cnt++;
    end

    task automatic wait_b(input string nm, output int lat);
        int start;
        bit got;
        start = cyc;
        got = 0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (b_i_ack === 1'b1 || b_d_ack === 1'b1) got = 1;
        end
        lat = cyc - start;
        if (!got) begin
            n_checks++; n_err++;
            $display("FAIL %s: no ack within 60 cycles", nm);
        end
    endtask

    initial begin
        int lat, e0;
        repeat (3) @(posedge clk);
        #1 b_rst = 1'b0;
        @(posedge clk); #1;
        e0 = b_en_cnt;
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 6'd3;
        wait_b("b_read", lat);
        chk("b_read_lat", 64'(lat), 64'd6);
        chk("b_read_data", b_d_rdata, 64'hDEADBEEF_00000013);
        @(posedge clk); #1 b_d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("b_en_once", 64'(b_en_cnt - e0), 64'd1);
        b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 6'd4; b_d_wdata = 64'h1111_2222_3333_4444;
        wait_b("b_write", lat);
        chk("b_write_lat", 64'(lat), 64'd6);
        @(posedge clk); #1 b_d_req = 1'b0;
        @(posedge clk); #1;
        b_d_req = 1'b1; b_d_we = 1'b0;
        wait_b("b_readback", lat);
        chk("b_readback", b_d_rdata, 64'h1111_2222_3333_4444);
        @(posedge clk); #1 b_d_req = 1'b0;
        @(posedge clk); #1;
        b_i_req = 1'b1; b_i_addr = 7'd7;
        wait_b("b_fetch", lat);
        chk("b_fetch_lat", 64'(lat), 64'd6);
        chk("b_fetch_data", 64'(b_i_rdata), 64'hDEADBEEF);
        @(posedge clk); #1 b_i_req = 1'b0;
        b_done = 1;
    end

    // ---------------- instance A directed sequence ----------------
    initial begin
        int lat, e0, da0;
        logic [63:0] rv;
        logic [31:0] iv;
        bit seq [$];

        // Reset with both requests high.
        i_req = 1'b1; i_addr = 7'd7; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd2;
        @(negedge clk);
        chk("rst_outs_1", 64'({i_ack, d_ack, m_en}), 64'd0);
        @(negedge clk);
        chk("rst_outs_2", 64'({i_ack, d_ack, m_en}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        wait_a("first_grant", lat);
        chk("first_grant_d", 64'({d_ack, i_ack}), 64'b10);
        chk("first_grant_data", d_rdata, init_word(2));
        @(posedge clk); #1 d_req = 1'b0;
        wait_a("second_grant", lat);
        chk("second_grant_i", 64'({d_ack, i_ack}), 64'b01);
        chk("second_grant_lat", 64'(lat), 64'd3);
        @(posedge clk); #1 i_req = 1'b0;

        // Data write then read.
        run_d("wr5", 1'b1, 6'd5, 64'h0123456789ABCDEF, lat, rv);
        chk("wr5_lat", 64'(lat), 64'd3);
        run_d("rd5", 1'b0, 6'd5, 64'h0, lat, rv);
        chk("rd5_lat", 64'(lat), 64'd3);
        chk("rd5_data", rv, 64'h0123456789ABCDEF);

        // Single fetches of both halves of word 3.
        run_i("fetch7", 7'd7, lat, iv);
        chk("fetch7_lat", 64'(lat), 64'd3);
        chk("fetch7_data", 64'(iv), 64'hDEADBEEF);
        run_i("fetch6", 7'd6, lat, iv);
        chk("fetch6_data", 64'(iv), 64'h00000013);

        // Contention for 24 cycles.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 7'd7; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd5;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (d_ack === 1'b1) seq.push_back(1'b1);
            if (i_ack === 1'b1) seq.push_back(1'b0);
        end
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
        chk("cont_ack_count", 64'(seq.size()), 64'd6);
        for (int j = 0; j < seq.size() && j < 6; j++)
            chk($sformatf("cont_ack_%0d_is_d", j), 64'(seq[j]), 64'((j % 2) == 0));

        // Reset during WAIT of a data write, then immediate fetch.
        @(posedge clk); #1;
        e0 = en_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd9; d_wdata = 64'hCAFEF00D_12345678;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        chk("rstwait_en_once", 64'(en_cnt - e0), 64'd1);
        da0 = dack_cnt;
        i_req = 1'b1; i_addr = 7'd7;
        wait_a("rstwait_fetch", lat);
        chk("rstwait_fetch_lat", 64'(lat), 64'd3);
        chk("rstwait_fetch_is_i", 64'({d_ack, i_ack}), 64'b01);
        @(posedge clk); #1 i_req = 1'b0;
        chk("rstwait_no_dack", 64'(dack_cnt - da0), 64'd0);
        run_d("rd9", 1'b0, 6'd9, 64'h0, lat, rv);
        chk("rd9_write_kept", rv, 64'hCAFEF00D_12345678);

        for (int t = 0; t < 500 && !b_done; t++) @(posedge clk);
        if (!b_done) begin
            n_checks++; n_err++;
            $display("FAIL b_sequence: did not complete");
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port 64-bit unified memory between the polirv instruction-fetch port and the data port.
- Arbitrates between the two requesters, sequences each memory access through a fixed-latency FSM, and returns data with a one-cycle ack pulse.
- Sits between the fd datapath and the memory, replacing the separate i_mem/d_mem buses once the processor goes multi-cycle.

Parameters:
- ADDR_BITS, 6, memory word-address width (64-bit words).
- MEM_LATENCY, 1, number of WAIT cycles between the m_en cycle and valid m_rdata; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_req  input  1  instruction fetch request, held until i_ack.
- i_addr  input  ADDR_BITS+1  instruction word address; bit 0 selects the 32-bit half (0=[31:0], 1=[63:32]); bits [ADDR_BITS:1] are the memory word.
- i_rdata  output  32  fetched instruction, valid while i_ack=1.
- i_ack  output  1  one-cycle completion pulse for the fetch.
- d_req  input  1  data access request, held until d_ack.
- d_we  input  1  1=write, 0=read; stable while d_req=1.
- d_addr  input  ADDR_BITS  data word address.
- d_wdata  input  64  write data.
- d_rdata  output  64  read data, valid while d_ack=1 after a read.
- d_ack  output  1  one-cycle completion pulse for the data access.
- m_en  output  1  memory access strobe, one cycle per transaction.
- m_we  output  1  memory write enable, qualified by m_en.
- m_addr  output  ADDR_BITS  memory word address.
- m_wdata  output  64  memory write data.
- m_rdata  input  64  memory read data.

Behaviour:
- Reset: all outputs are registered and reset to 0; state=IDLE; wait counter=0; last_grant=INSTR, so data wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not last_grant (round-robin).
  - On grant: latch the granted address, we, wdata and i_addr[0]; update last_grant; go to ACCESS.
- ACCESS (1 cycle):
  - m_en=1; m_we=d_we for a data grant, 0 for an instruction grant.
  - m_addr and m_wdata come from the latched values.
  - Load counter=MEM_LATENCY; go to WAIT.
- WAIT:
  - m_en=0, m_we=0; the counter decrements each cycle.
  - In the cycle the counter reaches 1, capture m_rdata into the response register; next state is RESP.
- RESP (1 cycle):
  - Pulse the granted requester's ack.
  - Instruction grant: i_rdata = the selected half of the captured word.
  - Data read: d_rdata = the captured word.
  - Data write: d_ack is still pulsed; d_rdata holds the captured m_rdata and is don't-care.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at edge k gives ACCESS in cycle k+1 and ack in cycle k+2+MEM_LATENCY. Default is 3 cycles after the request cycle.
- Throughput: one transaction per 3+MEM_LATENCY cycles. The arbiter returns to IDLE after RESP, so a req still high in the RESP cycle starts a new transaction.
- Requester rule:
  - The requester must deassert req in the cycle after it sees ack, or present the next request.
  - Address and data changes while req=1 before ack are ignored, because values are latched at grant.
  - If req drops before ack, the transaction still completes and ack is still pulsed.
- Non-granted requester: waits with no ack. Under continuous contention the grants alternate D, I, D, I, so neither requester starves.
- i_rdata/d_rdata hold their last value outside the ack cycle.
- i_ack and d_ack are never high in the same cycle.
- Reset mid-transaction: the FSM goes to IDLE and no ack is issued. Any write already strobed in ACCESS is not undone; the requester must reissue.
- Exactly one m_en pulse per granted transaction; m_en is never high outside ACCESS.

Decomposition:
- Shared package polirv_mem_pkg:
  - state encoding (IDLE, ACCESS, WAIT, RESP);
  - grant constants GRANT_I=0 and GRANT_D=1;
  - word width constant WORD_BITS=64.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from req[1:0] and last_grant, returning grant and valid.
- The counter and FSM stay in mem_arbiter.

Test Plan:
- Reset: assert rst for 2 cycles with both reqs high -> acks=0 and m_en=0 throughout; first grant after release goes to data.
- Single fetch: memory word 3 holds 0xDEADBEEF_00000013; i_req with i_addr=7 -> m_en one cycle with m_addr=3, m_we=0; i_ack 3 cycles after the request cycle with i_rdata=0xDEADBEEF.
- Data write then read:
  - Write d_addr=5, d_wdata=0x0123456789ABCDEF -> m_we=1 with m_en, then d_ack pulse.
  - Read d_addr=5 -> d_ack with d_rdata=0x0123456789ABCDEF.
- Contention: i_req and d_req both held high for 24 cycles -> acks alternate d, i, d, i, ...; six acks total; never simultaneous.
- MEM_LATENCY=4: single read -> ack 6 cycles after the request cycle; m_en pulses exactly once.
- Reset in WAIT: rst asserted during the WAIT of a d write -> no d_ack; m_en seen once; the FSM accepts a new i_req immediately after rst drops.
